// File: rtl/tk3_round_sched.sv
// TK3 tweakey schedule for SKINNY-128-384+: registered TK3 state advanced one round per step,
// with a shadow copy of the loaded key that is restored after the final round of a block.
module tk3_round_sched #(
    parameter int ROUNDS = 40,
    parameter int CW     = 6
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          load_i,
    input  logic [127:0]  key_in_i,
    input  logic          step_i,
    output logic [127:0]  tk3_out_o,
    output logic [63:0]   rtk_out_o,
    output logic [CW-1:0] round_o,
    output logic          last_o,
    output logic          loaded_o
);

    localparam logic [CW-1:0] LAST_ROUND = CW'(ROUNDS - 1);
    localparam int PT [16] = '{9, 15, 8, 13, 10, 14, 12, 11, 0, 1, 2, 3, 4, 5, 6, 7};

    logic [127:0]  tkState_q, tkState_d;
    logic [127:0]  shadow_q,  shadow_d;
    logic [CW-1:0] round_q,   round_d;
    logic          loaded_q,  loaded_d;

    function automatic logic [7:0] lfsr3(input logic [7:0] x);
        return {x[0] ^ x[6], x[7:1]};
    endfunction

    // One SKINNY round on TK3: cell permutation, then LFSR3 on rows 0-1 only.
    function automatic logic [127:0] roundUpdate(input logic [127:0] s);
        logic [127:0] t;
        t = '0;
        for (int i = 0; i < 16; i++) begin
            t[127-8*i -: 8] = s[127-8*PT[i] -: 8];
            if (i < 8) begin
                t[127-8*i -: 8] = lfsr3(s[127-8*PT[i] -: 8]);
            end
        end
        return t;
    endfunction

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tkState_q <= '0;
            shadow_q  <= '0;
            round_q   <= '0;
            loaded_q  <= 1'b0;
        end else begin
            tkState_q <= tkState_d;
            shadow_q  <= shadow_d;
            round_q   <= round_d;
            loaded_q  <= loaded_d;
        end
    end

    // Load wins over step; after the last round the shadow key is restored so no reload is needed.
    always_comb begin
        tkState_d = tkState_q;
        shadow_d  = shadow_q;
        round_d   = round_q;
        loaded_d  = loaded_q;
        if (load_i) begin
            tkState_d = key_in_i;
            shadow_d  = key_in_i;
            round_d   = '0;
            loaded_d  = 1'b1;
        end else if (step_i && loaded_q) begin
            if (round_q == LAST_ROUND) begin
                tkState_d = shadow_q;
                round_d   = '0;
            end else begin
                tkState_d = roundUpdate(tkState_q);
                round_d   = round_q + 1'b1;
            end
        end
    end

    always_comb begin
        tk3_out_o = tkState_q;
        rtk_out_o = tkState_q[127:64];
        round_o   = round_q;
        last_o    = loaded_q && (round_q == LAST_ROUND);
        loaded_o  = loaded_q;
    end

endmodule

// File: tb/tb_tk3_round_sched.sv
// Scoreboard bench for tk3_round_sched: a cell-array reference model predicts every cycle's outputs,
// a monitor pops and compares them one clock later.
module tb_tk3_round_sched;

    localparam int ROUNDS = 40;
    localparam int CW     = 6;

    logic          clk;
    logic          rst;
    logic          load;
    logic [127:0]  keyIn;
    logic          step;
    logic [127:0]  tk3Out;
    logic [63:0]   rtkOut;
    logic [CW-1:0] roundOut;
    logic          lastOut;
    logic          loadedOut;

    int errors = 0;
    int checks = 0;

    tk3_round_sched #(.ROUNDS(ROUNDS), .CW(CW)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .load_i    (load),
        .key_in_i  (keyIn),
        .step_i    (step),
        .tk3_out_o (tk3Out),
        .rtk_out_o (rtkOut),
        .round_o   (roundOut),
        .last_o    (lastOut),
        .loaded_o  (loadedOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [127:0] tk3;
        logic [CW-1:0] round;
        logic          last;
        logic          loaded;
    } expT;

    expT   expQ[$];
    string nameQ[$];

    // Reference model: sixteen byte cells, cell 0 being the most significant byte.
    int          permTable [16] = '{9, 15, 8, 13, 10, 14, 12, 11, 0, 1, 2, 3, 4, 5, 6, 7};
    logic [7:0]  mdlState  [16];
    logic [7:0]  mdlShadow [16];
    int          mdlRound;
    bit          mdlLoaded;

    function automatic int lfsrByte(input int x);
        return ((((x ^ (x >> 6)) & 1) << 7) | (x >> 1)) & 255;
    endfunction

    function automatic logic [127:0] mdlPack();
        logic [127:0] v;
        v = '0;
        for (int i = 0; i < 16; i++) v = (v << 8) | 128'(mdlState[i]);
        return v;
    endfunction

    task automatic modelUpdate(input bit r, input bit ld, input logic [127:0] key, input bit st);
        logic [7:0] tmp [16];
        if (r) begin
            for (int i = 0; i < 16; i++) begin
                mdlState[i]  = 8'h00;
                mdlShadow[i] = 8'h00;
            end
            mdlRound  = 0;
            mdlLoaded = 0;
        end else if (ld) begin
            for (int i = 0; i < 16; i++) begin
                mdlState[i]  = 8'((key >> (120 - 8 * i)) & 128'hFF);
                mdlShadow[i] = mdlState[i];
            end
            mdlRound  = 0;
            mdlLoaded = 1;
        end else if (st && mdlLoaded) begin
            if (mdlRound == ROUNDS - 1) begin
                for (int i = 0; i < 16; i++) mdlState[i] = mdlShadow[i];
                mdlRound = 0;
            end else begin
                for (int i = 0; i < 16; i++) tmp[i] = mdlState[permTable[i]];
                for (int i = 0; i < 8; i++)  tmp[i] = 8'(lfsrByte(int'(tmp[i])));
                for (int i = 0; i < 16; i++) mdlState[i] = tmp[i];
                mdlRound = mdlRound + 1;
            end
        end
    endtask

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs and push what the DUT must show after the next rising edge.
    task automatic applyStimulus(input bit r, input bit ld, input logic [127:0] key, input bit st,
                                 input string name);
        expT e;
        @(negedge clk);
        rst   = r;
        load  = ld;
        keyIn = key;
        step  = st;
        modelUpdate(r, ld, key, st);
        e.tk3    = mdlPack();
        e.round  = CW'(mdlRound);
        e.loaded = mdlLoaded;
        e.last   = mdlLoaded && (mdlRound == ROUNDS - 1);
        expQ.push_back(e);
        nameQ.push_back(name);
    endtask

    // Directed check against a hand-derived constant, sampled after the edge that consumed the last stimulus.
    task automatic checkConst(input string name, input logic [127:0] expTk3, input int expRound,
                              input bit expLast);
        @(posedge clk);
        #1;
        checkOutput({name, ".tk3"},   tk3Out, expTk3);
        checkOutput({name, ".round"}, 128'(roundOut), 128'(expRound));
        checkOutput({name, ".last"},  128'(lastOut), 128'(expLast));
    endtask

    expT   monE;
    string monName;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (expQ.size() > 0) begin
                monE    = expQ.pop_front();
                monName = nameQ.pop_front();
                checkOutput({monName, ".tk3"},    tk3Out,             monE.tk3);
                checkOutput({monName, ".rtk"},    128'(rtkOut),       128'(monE.tk3[127:64]));
                checkOutput({monName, ".round"},  128'(roundOut),     128'(monE.round));
                checkOutput({monName, ".last"},   128'(lastOut),      128'(monE.last));
                checkOutput({monName, ".loaded"}, 128'(loadedOut),    128'(monE.loaded));
            end
        end
    end

    logic [127:0] keyK;
    logic [127:0] rk;
    int           waitCycles;

    initial begin
        rst = 1'b1; load = 1'b0; keyIn = '0; step = 1'b0;
        for (int i = 0; i < 16; i++) begin
            mdlState[i] = 8'h00; mdlShadow[i] = 8'h00;
        end
        mdlRound = 0; mdlLoaded = 0;

        applyStimulus(1, 0, '0, 0, "reset");
        applyStimulus(1, 1, {4{32'hDEADBEEF}}, 1, "resetPrio");
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, '0, 1, "stepNoLoad");
        checkConst("afterReset", 128'h0, 0, 0);

        applyStimulus(0, 1, 128'h01 << 120, 0, "loadCell0");
        applyStimulus(0, 0, '0, 1, "cell0Step1");
        checkConst("cell0Step1", 128'h0000000000000000_0100000000000000, 1, 0);
        applyStimulus(0, 0, '0, 1, "cell0Step2");
        checkConst("cell0Step2", 128'h0000800000000000_0000000000000000, 2, 0);

        applyStimulus(0, 1, 128'h02 << 104, 0, "loadCell2");
        applyStimulus(0, 0, '0, 1, "cell2Step");
        checkConst("cell2Step", 128'h02 << 40, 1, 0);
        applyStimulus(0, 1, 128'h02 << 56, 0, "loadCell8a");
        applyStimulus(0, 0, '0, 1, "lfsr02");
        checkConst("lfsr02", 128'h01 << 104, 1, 0);
        applyStimulus(0, 1, 128'h41 << 56, 0, "loadCell8b");
        applyStimulus(0, 0, '0, 1, "lfsr41");
        checkConst("lfsr41", 128'h20 << 104, 1, 0);

        keyK = {$urandom, $urandom, $urandom, $urandom};
        applyStimulus(0, 1, keyK, 0, "loadK");
        for (int i = 0; i < ROUNDS - 1; i++) applyStimulus(0, 0, '0, 1, "blockA");
        applyStimulus(0, 0, '0, 0, "holdLast");
        @(posedge clk); #1;
        checkOutput("lastRound.round", 128'(roundOut), 128'(ROUNDS - 1));
        checkOutput("lastRound.last",  128'(lastOut),  128'h1);
        applyStimulus(0, 0, '0, 1, "wrap");
        checkConst("wrap", keyK, 0, 0);
        for (int i = 0; i < ROUNDS; i++) applyStimulus(0, 0, '0, 1, "blockB");

        rk = {$urandom, $urandom, $urandom, $urandom};
        applyStimulus(0, 1, rk, 0, "loadMid");
        for (int i = 0; i < 17; i++) applyStimulus(0, 0, '0, 1, "toR17");
        rk = {$urandom, $urandom, $urandom, $urandom};
        applyStimulus(0, 1, rk, 1, "loadPlusStep");
        checkConst("loadPlusStep", rk, 0, 0);

        for (int i = 0; i < 20; i++) applyStimulus(0, 0, '0, 1, "toR20");
        applyStimulus(1, 1, ~rk, 0, "rstPlusLoad");
        applyStimulus(0, 0, '0, 1, "stepAfterRst");
        checkConst("stepAfterRst", 128'h0, 0, 0);
        rk = {$urandom, $urandom, $urandom, $urandom};
        applyStimulus(0, 1, rk, 0, "freshLoad");
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, '0, 1, "resume");

        for (int i = 0; i < 400; i++) begin
            rk = {$urandom, $urandom, $urandom, $urandom};
            applyStimulus(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 4), rk,
                          ($urandom_range(0, 99) < 70), "random");
        end
        applyStimulus(0, 0, '0, 0, "idle");

        waitCycles = 0;
        while (expQ.size() > 0 && waitCycles < 20) begin
            @(negedge clk);
            waitCycles++;
        end
        checks++;
        if (expQ.size() > 0) begin
            errors++;
            $display("[TB] FAIL drain: %0d entries left, expected 0", expQ.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
